// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared RV32I types and constants for the fetch stage:
//               opcode enum, fetch FSM states, reset PC and NOP encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0060;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory request/response handshake bundle.
//               master = fetch stage, slave = instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  modport master (output imem_read, output imem_address,
                  input  imem_rdata, input imem_resp);
  modport slave  (input  imem_read, input imem_address,
                  output imem_rdata, output imem_resp);
endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register {valid, pc, instr} with load and
//               flush controls, plus combinational decode-field slices.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,   // clears valid only; flush beats load
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output rv32i_opcode opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  // Register update: reset to an invalid NOP, flush to a bubble, or load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o  = valid_q;
  assign pc_o     = pc_q;
  assign instr_o  = instr_q;
  assign opcode_o = rv32i_opcode'(instr_q[6:0]);
  assign funct3_o = instr_q[14:12];
  assign funct7_o = instr_q[31:25];
  assign rd_o     = instr_q[11:7];
  assign rs1_o    = instr_q[19:15];
  assign rs2_o    = instr_q[24:20];

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch with PC, one-entry skid buffer for stalls,
//               redirect handling (including discard of a stale in-flight
//               response) and an integrated IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  fetch_stage_if.master              imem,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       if_id_valid,
  output logic [31:0]                if_id_pc,
  output logic [31:0]                if_id_instr,
  output fetch_stage_pkg::rv32i_opcode if_id_opcode,
  output logic [2:0]                 if_id_funct3,
  output logic [6:0]                 if_id_funct7,
  output logic [4:0]                 if_id_rd,
  output logic [4:0]                 if_id_rs1,
  output logic [4:0]                 if_id_rs2
);
  import fetch_stage_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic         load_d, flush_d;
  logic [31:0]  ld_pc_d, ld_instr_d;

  // HOLD never issues: the stalled instruction already sits in the skid buffer.
  assign imem.imem_read    = !rst && (state_q != HOLD);
  assign imem.imem_address = pc_q;

  // State, PC and skid buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // Next-state, PC and IF/ID control; redirect overrides stall and resp.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    load_d       = 1'b0;
    flush_d      = 1'b0;
    ld_pc_d      = pc_q;
    ld_instr_d   = imem.imem_rdata;

    if (redirect) begin
      flush_d = 1'b1;
      pc_d    = redirect_pc;
      // A FETCH without a response leaves the old request in flight, so its
      // eventual response must be swallowed before the target counts.
      if ((state_q == FETCH && !imem.imem_resp) || state_q == DISCARD)
        state_d = DISCARD;
      else
        state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.imem_resp) begin
            if (!stall) begin
              load_d = 1'b1;
              pc_d   = pc_q + 32'd4;
            end else begin
              skid_pc_d    = pc_q;
              skid_instr_d = imem.imem_rdata;
              state_d      = HOLD;
            end
          end else if (!stall) begin
            flush_d = 1'b1;  // bubble
          end
        end
        HOLD: begin
          if (!stall) begin
            load_d     = 1'b1;
            ld_pc_d    = skid_pc_q;
            ld_instr_d = skid_instr_q;
            pc_d       = pc_q + 32'd4;
            state_d    = FETCH;
          end
        end
        DISCARD: begin
          if (imem.imem_resp) begin
            flush_d = 1'b1;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_d),
    .flush_i  (flush_d),
    .pc_i     (ld_pc_d),
    .instr_i  (ld_instr_d),
    .valid_o  (if_id_valid),
    .pc_o     (if_id_pc),
    .instr_o  (if_id_instr),
    .opcode_o (if_id_opcode),
    .funct3_o (if_id_funct3),
    .funct7_o (if_id_funct7),
    .rd_o     (if_id_rd),
    .rs1_o    (if_id_rs1),
    .rs2_o    (if_id_rs2)
  );

endmodule
`default_nettype wire
